// File: rtl/game_pkg.sv
// Shared types and width helpers for the memory-game blocks.
package game_pkg;

    localparam int unsigned PATTERN_W   = 4;
    localparam int unsigned MAX_LEN_DEF = 16;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLatch,
        StPlayGap,
        StPlayShow,
        StWaitKey,
        StCheck,
        StFail,
        StWin
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/press_detect.sv
// Rising-edge detector for the key pad: a press is any key down after a cycle with none down.
module press_detect
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PATTERN_W-1:0] key,
    output logic                 press,
    output logic [PATTERN_W-1:0] press_val
);

    logic [PATTERN_W-1:0] key_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= '0;
        end else begin
            key_prev_q <= key;
        end
    end

    always_comb begin
        press     = (key != '0) && (key_prev_q == '0);
        press_val = key;
    end

endmodule

// File: rtl/sequence_checker.sv
// Memory-game checker: fetches one pattern per round, plays the stored sequence back and
// matches the player's presses against it.
module sequence_checker
    import game_pkg::*;
#(
    parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
    parameter int unsigned DISP_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PATTERN_W-1:0]         seq,
    output logic                         go_to_next_seq,
    input  logic [PATTERN_W-1:0]         key,
    output logic [PATTERN_W-1:0]         show_item,
    output logic                         show_active,
    output logic                         await_input,
    output logic [$clog2(MAX_LEN+1)-1:0] round,
    output logic                         fail,
    output logic                         win
);

    localparam int unsigned RW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = width_of(MAX_LEN);
    localparam int unsigned CW = width_of((DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES);

    state_e               state_q, state_d;
    logic [RW-1:0]        round_q, round_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PATTERN_W-1:0] cap_q, cap_d;
    logic                 fail_q, fail_d;
    logic                 win_q, win_d;
    logic [PATTERN_W-1:0] item_buf_q [MAX_LEN];
    logic                 buf_we;
    logic                 idx_last;
    logic                 press;
    logic [PATTERN_W-1:0] press_val;

    press_detect u_press_detect (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .press     (press),
        .press_val (press_val)
    );

    assign idx_last = (RW'(idx_q) == (round_q - RW'(1)));

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        fail_d  = fail_q;
        win_d   = win_q;
        buf_we  = 1'b0;
        unique case (state_q)
            StIdle, StFail, StWin: begin
                if (start) begin
                    state_d = StFetch;
                    round_d = '0;
                    fail_d  = 1'b0;
                    win_d   = 1'b0;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                // An all-zero pattern cannot be pressed, so ask for another one.
                if (seq == '0) begin
                    state_d = StFetch;
                end else begin
                    buf_we  = 1'b1;
                    round_d = round_q + RW'(1);
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StPlayGap;
                end
            end
            StPlayGap: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StPlayShow;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPlayShow: begin
                if (cnt_q == CW'(DISP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = StWaitKey;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = StPlayGap;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitKey: begin
                if (press) begin
                    cap_d   = press_val;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cap_q != item_buf_q[idx_q]) begin
                    fail_d  = 1'b1;
                    state_d = StFail;
                end else if (!idx_last) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StWaitKey;
                end else if (round_q == RW'(MAX_LEN)) begin
                    win_d   = 1'b1;
                    state_d = StWin;
                end else begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            round_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            fail_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            fail_q  <= fail_d;
            win_q   <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            item_buf_q[round_q[IW-1:0]] <= seq;
        end
    end

    always_comb begin
        go_to_next_seq = (state_q == StFetch) && !reset;
        show_item      = (state_q == StPlayShow) ? item_buf_q[idx_q] : '0;
        show_active    = (state_q == StPlayGap) || (state_q == StPlayShow);
        await_input    = (state_q == StWaitKey);
        round          = round_q;
        fail           = fail_q;
        win            = win_q;
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with a small sequence_gen model driving seq.
module tb_sequence_checker;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned DISP    = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned RW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    key = 4'b0000;
    logic [3:0]    seq;
    logic [3:0]    show_item;
    logic          go_to_next_seq, show_active, await_input, fail, win;
    logic [RW-1:0] round;

    always #5 clk = ~clk;

    sequence_checker #(
        .MAX_LEN     (MAX_LEN),
        .DISP_CYCLES (DISP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .seq            (seq),
        .go_to_next_seq (go_to_next_seq),
        .key            (key),
        .show_item      (show_item),
        .show_active    (show_active),
        .await_input    (await_input),
        .round          (round),
        .fail           (fail),
        .win            (win)
    );

    // sequence_gen model: advances on each pulse, reset with the same reset.
    logic [3:0] gen_vals [16];
    int         gen_ptr = 0;
    always @(posedge clk) begin
        if (reset) gen_ptr <= 0;
        else if (go_to_next_seq) gen_ptr <= gen_ptr + 1;
    end
    assign seq = gen_vals[gen_ptr[3:0]];

    int cyc = 0, n_pulses = 0, last_pulse = 0, pulse_gap = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (go_to_next_seq) begin
            n_pulses   <= n_pulses + 1;
            pulse_gap  <= cyc - last_pulse;
            last_pulse <= cyc;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          st;
        logic [3:0]    k;
        logic [3:0]    it;
        logic          act;
        logic          awt;
        logic          gn;
        logic [RW-1:0] rnd;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic st, input logic [3:0] k, input logic [3:0] it,
                       input logic act, input logic awt, input logic gn,
                       input logic [RW-1:0] rnd, input int n = 1);
        for (int i = 0; i < n; i++) vecs.push_back('{st, k, it, act, awt, gn, rnd});
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, go_to_next_seq, show_item, show_active, await_input, round, fail, win};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        key   = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One-cycle press; returns after the CHECK cycle's edge.
    task automatic press(input logic [3:0] k);
        key = k;
        @(negedge clk);
        key = 4'b0000;
        @(negedge clk);
    endtask

    task automatic wait_await(input string name, input int budget);
        int k = 0;
        while (!await_input && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, await_input}, 32'd1);
    endtask

    task automatic wait_show(input string name, input int budget);
        int k = 0;
        while (show_item == 4'b0000 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, show_item != 4'b0000}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] items [4];
        int         exp_pulses [5];
        int         p0;

        for (int i = 0; i < 16; i++) gen_vals[i] = 4'b0001;
        gen_vals[0] = 4'b0000;
        gen_vals[1] = 4'b0010;
        gen_vals[2] = 4'b0100;

        // Test 1/2: first two rounds, cycle by cycle.
        add(1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 1, GAP);
        add(0, 4'b0000, 4'b0010, 1, 0, 0, 1, DISP);
        add(0, 4'b0010, 4'b0000, 0, 1, 0, 1);
        add(0, 4'b0010, 4'b0000, 0, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 2, GAP);
        add(0, 4'b0000, 4'b0010, 1, 0, 0, 2, DISP);
        add(0, 4'b0000, 4'b0000, 1, 0, 0, 2, GAP);
        add(0, 4'b0000, 4'b0100, 1, 0, 0, 2, DISP);
        add(0, 4'b0000, 4'b0000, 0, 1, 0, 2, 2);

        do_reset();
        check("reset_outputs", outs(), 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st;
            key   = vecs[i].k;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {20'd0, vecs[i].gn, vecs[i].it, vecs[i].act, vecs[i].awt, vecs[i].rnd, 2'b00});
            @(negedge clk);
        end
        start = 1'b0;
        key   = 4'b0000;

        // Test 3: round 2, first item right, second wrong.
        press(4'b0010);
        check("r2_item0_await", {31'd0, await_input}, 32'd1);
        key = 4'b1000;
        @(negedge clk);
        key = 4'b0000;
        check("fail_not_early", {30'd0, fail, await_input}, 32'd0);
        @(negedge clk);
        check("fail_latency", {30'd0, fail, await_input}, 32'b10);
        p0 = n_pulses;
        press(4'b0100);
        press(4'b0010);
        check("fail_hold", {27'd0, fail, win, await_input, RW'(round)}, {27'd0, 3'b100, 3'd2});
        check("fail_no_fetch", n_pulses - p0, 32'd0);

        // Test 4/5: zero pattern discarded once, then a full game to win.
        gen_vals[1] = 4'b0001;
        gen_vals[2] = 4'b0000;
        gen_vals[3] = 4'b0010;
        gen_vals[4] = 4'b0100;
        gen_vals[5] = 4'b1000;
        gen_vals[6] = 4'b0001;
        items[0] = 4'b0001;
        items[1] = 4'b0010;
        items[2] = 4'b0100;
        items[3] = 4'b1000;
        exp_pulses[1] = 1;
        exp_pulses[2] = 3;
        exp_pulses[3] = 4;
        exp_pulses[4] = 5;
        do_reset();
        p0 = n_pulses;
        pulse_start();
        for (int r = 1; r <= 4; r++) begin
            wait_await($sformatf("await_r%0d", r), 100);
            check($sformatf("round_r%0d", r), {29'd0, round}, r);
            check($sformatf("pulses_r%0d", r), n_pulses - p0, exp_pulses[r]);
            if (r == 2) check("zero_refetch_gap", {31'd0, pulse_gap >= 2 && pulse_gap <= 3}, 32'd1);
            for (int i = 0; i < r; i++) press(items[i]);
        end
        check("win_set", {29'd0, win, fail, await_input}, 32'b100);
        repeat (10) @(negedge clk);
        check("win_no_fifth_fetch", n_pulses - p0, 32'd5);
        check("win_hold", {28'd0, win, round}, {28'd0, 1'b1, 3'd4});
        pulse_start();
        wait_show("restart_show", 20);
        check("restart_clears", {28'd0, win, round}, {28'd0, 1'b0, 3'd1});

        // Test 6: ignored playback press, ignored start, held key, reset mid-playback.
        gen_vals[1] = 4'b0001;
        gen_vals[2] = 4'b0010;
        gen_vals[3] = 4'b0100;
        do_reset();
        pulse_start();
        wait_await("t6_await_r1", 50);
        press(4'b0001);
        wait_show("t6_show_r2", 20);
        key = 4'b0001;
        @(negedge clk);
        key = 4'b0000;
        wait_await("t6_await_r2", 50);
        repeat (3) @(negedge clk);
        check("playback_press_ignored", {31'd0, await_input}, 32'd1);
        pulse_start();
        @(negedge clk);
        check("start_ignored", {28'd0, await_input, round}, {28'd0, 1'b1, 3'd2});
        key = 4'b0001;
        repeat (4) @(negedge clk);
        key = 4'b0000;
        @(negedge clk);
        check("held_single_event", {27'd0, fail, await_input, round}, {27'd0, 2'b01, 3'd2});
        press(4'b0010);
        wait_show("t6_show_r3", 20);
        check("t6_round3", {29'd0, round}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_play", outs(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
